// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester arbiter (core and loader/debug port) in front of a single
//   synchronous-read memory port. Each access takes exactly two cycles from
//   the request-sampling edge to the one-cycle ack pulse. The loader can lock
//   the port for back-to-back accesses. A waiting core is let in after
//   LOCK_MAX consecutive locked loader accesses.
//
//   Optional feature macro: MEMARB_RR_EN
//     defined   -> simultaneous requests in IDLE are granted round-robin
//     undefined -> the core always wins simultaneous requests
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   c_req/c_we/c_size       core request, write flag, size (1 = full word)
//   c_addr/c_wdata          core byte address and write data
//   c_ack                   core access complete (one-cycle pulse)
//   l_req/l_we/l_lock       loader request, write flag, keep-grant flag
//   l_addr/l_wdata          loader byte address and write data
//   l_ack                   loader access complete (one-cycle pulse)
//   rdata                   read data, valid only while an ack is high
//   m_we/m_size/m_addr/
//   m_wdata                 memory request, driven only in the access cycle
//   m_rdata                 memory read data, one cycle after the address
module mem_port_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic        c_size,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  input  logic        l_req,
  input  logic        l_we,
  input  logic        l_lock,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_ack,
  output logic [31:0] rdata,
  output logic        m_we,
  output logic        m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_C = 2'd1,
    ACC_L = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_MAX - 1);

  state_t     r_state, w_state_next;
  logic       r_owner_l, w_owner_l_next;       // 1 = loader owns the access
  logic [3:0] r_lock_cnt, w_lock_cnt_next;     // locked continuations so far
  logic       r_force_core, w_force_core_next; // core wins the next IDLE
  logic       w_grant_l;                       // IDLE arbitration result
  logic       w_locked_cont;                   // loader asks to keep the port
  logic       w_lock_limit;                    // waiting core must be let in

`ifdef MEMARB_RR_EN
  logic       r_rr_favor_l, w_rr_favor_l_next; // 1 = loader wins next tie
`endif

  assign w_locked_cont = r_owner_l && l_req && l_lock;
  assign w_lock_limit  = (r_lock_cnt == LOCK_LAST) && c_req;

  // Arbitration among requests seen in IDLE.
  always_comb begin
    w_grant_l = 1'b0;
    if (r_force_core && c_req) begin
      w_grant_l = 1'b0;
    end else if (c_req && l_req) begin
`ifdef MEMARB_RR_EN
      w_grant_l = r_rr_favor_l;
`else
      w_grant_l = 1'b0;
`endif
    end else begin
      w_grant_l = l_req;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next      = r_state;
    w_owner_l_next    = r_owner_l;
    w_lock_cnt_next   = r_lock_cnt;
    w_force_core_next = r_force_core;
`ifdef MEMARB_RR_EN
    w_rr_favor_l_next = r_rr_favor_l;
`endif
    unique case (r_state)
      IDLE: begin
        if (c_req || l_req) begin
          w_force_core_next = 1'b0;
          if (w_grant_l) begin
            w_state_next   = ACC_L;
            w_owner_l_next = 1'b1;
`ifdef MEMARB_RR_EN
            w_rr_favor_l_next = 1'b0;
`endif
          end else begin
            w_state_next    = ACC_C;
            w_owner_l_next  = 1'b0;
            w_lock_cnt_next = 4'd0;
`ifdef MEMARB_RR_EN
            w_rr_favor_l_next = 1'b1;
`endif
          end
        end
      end
      ACC_C, ACC_L: begin
        w_state_next = RESP;
      end
      RESP: begin
        if (w_locked_cont && !w_lock_limit) begin
          // Locked continuation: skip IDLE. The counter saturates so an
          // unlimited stream still yields promptly once the core shows up.
          w_state_next = ACC_L;
          if (r_lock_cnt != LOCK_LAST) begin
            w_lock_cnt_next = r_lock_cnt + 4'd1;
          end
`ifdef MEMARB_RR_EN
          w_rr_favor_l_next = 1'b0;
`endif
        end else begin
          w_state_next      = IDLE;
          w_lock_cnt_next   = 4'd0;
          // Remember that the loader was cut off so the core is not lost
          // to the normal arbitration rule in the following IDLE cycle.
          w_force_core_next = w_locked_cont && w_lock_limit;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner_l    <= 1'b0;
      r_lock_cnt   <= 4'd0;
      r_force_core <= 1'b0;
`ifdef MEMARB_RR_EN
      r_rr_favor_l <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_owner_l    <= w_owner_l_next;
      r_lock_cnt   <= w_lock_cnt_next;
      r_force_core <= w_force_core_next;
`ifdef MEMARB_RR_EN
      r_rr_favor_l <= w_rr_favor_l_next;
`endif
    end
  end

  // Outputs are decoded from the state only, so an asynchronous reset
  // clears the memory request and acks in the same instant.
  always_comb begin
    m_we    = 1'b0;
    m_size  = 1'b0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    c_ack   = 1'b0;
    l_ack   = 1'b0;
    rdata   = 32'd0;
    unique case (r_state)
      ACC_C: begin
        m_we    = c_we;
        m_size  = c_size;
        m_addr  = c_addr;
        m_wdata = c_wdata;
      end
      ACC_L: begin
        m_we    = l_we;
        m_size  = 1'b1;
        m_addr  = l_addr;
        m_wdata = l_wdata;
      end
      RESP: begin
        c_ack = !r_owner_l;
        l_ack = r_owner_l;
        rdata = m_rdata;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LOCK_MAX = 16;
`ifdef MEMARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, c_size, c_ack;
  logic [31:0] c_addr, c_wdata;
  logic        l_req, l_we, l_lock, l_ack;
  logic [31:0] l_addr, l_wdata;
  logic [31:0] rdata;
  logic        m_we, m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_ack(c_ack),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr),
    .l_wdata(l_wdata), .l_ack(l_ack),
    .rdata(rdata), .m_we(m_we), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read, read-first memory of 256 words.
  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  logic        mem_init;

  function automatic logic [31:0] pat(input int i);
    if (i == 16) return 32'h12345678;
    return 32'hA5000000 | 32'(i << 8) | 32'(i ^ 8'h3C);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (m_we) begin
      mem[m_addr[9:2]] <= m_wdata;
    end
    m_rdata <= mem[m_addr[9:2]];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          who_l;
    bit          we;
    bit          sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          chk_rd;
  } vec_t;

  // One isolated access: bus at +1, ack/rdata at +2, idle afterwards.
  task automatic do_access(input vec_t v);
    if (v.who_l) begin
      l_req = 1; l_we = v.we; l_lock = 0; l_addr = v.addr; l_wdata = v.wd;
    end else begin
      c_req = 1; c_we = v.we; c_size = v.sz; c_addr = v.addr; c_wdata = v.wd;
    end
    @(posedge clk); #1;
    chk("acc_bus", {m_we, m_size, m_addr, m_wdata, c_ack, l_ack},
        {v.we, (v.who_l ? 1'b1 : v.sz), v.addr, v.wd, 2'b00});
    @(posedge clk); #1;
    chk("ack", {c_ack, l_ack}, {!v.who_l, v.who_l});
    if (v.chk_rd) chk("rdata", rdata, v.exp_rd);
    chk("resp_bus_quiet", {m_we, m_size, m_addr, m_wdata}, 0);
    @(posedge clk); #1;
    c_req = 0; l_req = 0;
    chk("after_ack_quiet", {c_ack, l_ack, m_we, m_addr, rdata}, 0);
    $display("txn %s %s addr=%08h wdata=%08h rdata=%08h",
             v.who_l ? "loader" : "core", v.we ? "WR" : "RD", v.addr, v.wd, v.exp_rd);
  endtask

  // Locked loader write stream; the core issues a read of 0x200 once
  // pre_acks loader acks were seen. Returns the number of loader acks
  // seen before the core ack and the read data of the core access.
  task automatic lock_stream(input int pre_acks, output int l_before_c, output logic [31:0] core_rd);
    int k = 0, acks = 0, last = 0, cyc = 0;
    bit prev_l = 0, prev_c = 0, core_on = 0, core_done = 0, ending = 0, done = 0;
    l_before_c = -1; core_rd = 'x;
    l_req = 1; l_lock = 1; l_we = 1; l_addr = 32'h200; l_wdata = 0;
    while (!done && cyc < 400) begin
      @(posedge clk); #1; cyc++;
      if (prev_c) c_req = 0;
      if (prev_l) begin
        if (ending) begin
          l_req = 0; l_lock = 0; done = 1;
        end else begin
          k++;
          l_addr = 32'h200 + 32'(4 * (k % 32));
          l_wdata = 32'(k);
          if (core_done) begin ending = 1; l_lock = 0; end
        end
      end
      if (l_ack) begin
        if (acks > 0 && !core_on) chk("lock_gap", 32'(cyc - last), 2);
        acks++; last = cyc;
      end
      if (c_ack) begin core_done = 1; core_rd = rdata; l_before_c = acks; end
      if (!core_on && acks == pre_acks) begin
        core_on = 1; c_req = 1; c_we = 0; c_size = 1; c_addr = 32'h200; c_wdata = 0;
      end
      prev_l = l_ack; prev_c = c_ack;
    end
    chk("stream_done", done, 1);
    $display("txn lock stream: %0d loader acks, core acked after %0d loader acks, core rdata=%08h",
             acks, l_before_c, core_rd);
  endtask

  task automatic new_l(input bit draining);
    l_req = 1;
    l_we = 1'($urandom_range(0, 1));
    l_addr = 32'($urandom_range(0, 15)) << 2;
    l_wdata = $urandom;
    l_lock = draining ? 1'b0 : ($urandom_range(0, 3) != 0);
  endtask

  // Randomized traffic checked against a transaction-timing model:
  // a grant at edge g puts the request on the bus after g, acks after g+1,
  // and at edge g+2 either continues the loader lock or frees the port.
  task automatic random_phase(input int n_cycles);
    bit act = 0, own_l = 0, force_c = 0, rr_l = 0, draining = 0;
    bit grant, grant_l, exp_c, exp_l, prev_c = 0, prev_l = 0;
    int g_edge = -10, free_edge = 1, run = 0, e = 0, n_txn = 0;
    bit t_we, t_sz;
    logic [31:0] t_addr, t_wd, exp_rd;
    logic [65:0] exp_bus;
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    c_req = 0; l_req = 0; l_lock = 0;
    t_we = 0; t_sz = 0; t_addr = 0; t_wd = 0;
    while (e < n_cycles + 400) begin
      @(posedge clk); e++;
      if (e >= n_cycles) draining = 1;
      grant = 0; grant_l = 0;
      if (act && e == g_edge + 2) begin
        if (own_l && l_req && l_lock && !(run == LOCK_MAX - 1 && c_req)) begin
          grant = 1; grant_l = 1;
          if (run < LOCK_MAX - 1) run++;
        end else begin
          act = 0; force_c = own_l && l_req && l_lock; run = 0; free_edge = e + 1;
        end
      end else if (!act && e >= free_edge && (c_req || l_req)) begin
        grant = 1;
        if (force_c && c_req) grant_l = 0;
        else if (c_req && l_req) grant_l = RR_EN ? rr_l : 1'b0;
        else grant_l = l_req;
        run = 0; force_c = 0;
      end
      #1;
      // requesters: release after an ack, maybe issue a new request
      if (prev_c) c_req = 0;
      if (!c_req && !draining && $urandom_range(0, 2) == 0) begin
        c_req = 1; c_we = 1'($urandom_range(0, 1)); c_size = 1'($urandom_range(0, 1));
        c_addr = 32'($urandom_range(0, 15)) << 2; c_wdata = $urandom;
      end
      if (prev_l) begin
        if (l_lock) new_l(draining);
        else l_req = 0;
      end
      if (!l_req && !draining && $urandom_range(0, 2) == 0) new_l(draining);
      #1;
      if (grant) begin
        act = 1; g_edge = e; own_l = grant_l; rr_l = !grant_l;
        t_we = grant_l ? l_we : c_we;
        t_sz = grant_l ? 1'b1 : c_size;
        t_addr = grant_l ? l_addr : c_addr;
        t_wd = grant_l ? l_wdata : c_wdata;
      end
      exp_c = 0; exp_l = 0; exp_rd = 0; exp_bus = 0;
      if (act && e == g_edge) begin
        exp_bus = {t_we, t_sz, t_addr, t_wd};
      end else if (act && e == g_edge + 1) begin
        exp_c = !own_l; exp_l = own_l; exp_rd = shadow[t_addr[9:2]];
      end
      chk("rnd_bus", {c_ack, l_ack, m_we, m_size, m_addr, m_wdata}, {exp_c, exp_l, exp_bus});
      chk("rnd_rdata", rdata, exp_rd);
      if (exp_c || exp_l) begin
        n_txn++;
        $display("txn rnd %0d %s %s addr=%08h wdata=%08h rdata=%08h",
                 n_txn, own_l ? "loader" : "core", t_we ? "WR" : "RD", t_addr, t_wd, exp_rd);
        if (t_we) shadow[t_addr[9:2]] = t_wd;
      end
      prev_c = exp_c; prev_l = exp_l;
      if (draining && !act && !c_req && !l_req) break;
    end
    chk("rnd_drained", {act, c_req, l_req}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    logic [3:0] got;
    int n, l_before;
    bit prev_c, prev_l;
    logic [31:0] core_rd;

    reset = 1; mem_init = 1;
    c_req = 0; c_we = 0; c_size = 0; c_addr = 0; c_wdata = 0;
    l_req = 0; l_we = 0; l_lock = 0; l_addr = 0; l_wdata = 0;

    vt[0] = '{0, 0, 1, 32'h40, 32'h0, 32'h12345678, 1};
    vt[1] = '{1, 1, 1, 32'h80, 32'hDEADBEEF, 32'h0, 0};
    vt[2] = '{0, 0, 0, 32'h80, 32'h0, 32'hDEADBEEF, 1};
    vt[3] = '{0, 1, 1, 32'h44, 32'hCAFEF00D, 32'h0, 0};
    vt[4] = '{1, 0, 1, 32'h44, 32'h00000055, 32'hCAFEF00D, 1};
    vt[5] = '{1, 0, 1, 32'h0, 32'h0, pat(0), 1};
    vt[6] = '{0, 0, 1, 32'hFC, 32'h0, pat(63), 1};
    vt[7] = '{1, 1, 1, 32'h40, 32'h0BADCAFE, 32'h0, 0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {c_ack, l_ack, m_we, m_size, m_addr, m_wdata, rdata}, 0);
    mem_init = 0; reset = 0;
    @(posedge clk); #1;
    chk("post_reset_idle", {c_ack, l_ack, m_we, m_size, m_addr, m_wdata, rdata}, 0);

    // isolated accesses
    for (int i = 0; i < 8; i++) do_access(vt[i]);

    // both requesters held continuously
    c_req = 1; c_we = 0; c_size = 1; c_addr = 32'h4; c_wdata = 0;
    l_req = 1; l_we = 0; l_lock = 0; l_addr = 32'h8; l_wdata = 0;
    got = 'x; n = 0; prev_c = 0; prev_l = 0;
    for (int cyc = 0; cyc < 60 && (c_req || l_req); cyc++) begin
      @(posedge clk); #1;
      if (prev_c && n >= 4) c_req = 0;
      if (prev_l && n >= 4) l_req = 0;
      if (c_ack || l_ack) begin
        if (n < 4) got[n] = l_ack;
        n++;
      end
      prev_c = c_ack; prev_l = l_ack;
    end
    chk("alt_grants", got, RR_EN ? 4'b1010 : 4'b0000);
    chk("alt_drain", {c_req, l_req}, 0);
    $display("txn simultaneous requests: grant order (bit0 first, 1=loader) %b", got);
    @(posedge clk); #1;

    // unlimited locked stream, then the core arrives
    lock_stream(40, l_before, core_rd);
    chk("yield_bound", (l_before >= 40) && (l_before - 40 <= LOCK_MAX), 1);
    chk("stream_core_rd", core_rd, 32'd32);
    repeat (2) @(posedge clk);
    #1;

    // core arrives early in a fresh stream: exactly LOCK_MAX loader accesses first
    lock_stream(3, l_before, core_rd);
    chk("lock_limit", 32'(l_before), 32'(LOCK_MAX));
    chk("limit_core_rd", core_rd, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // reset during a loader write access
    l_req = 1; l_we = 1; l_lock = 0; l_addr = 32'h300; l_wdata = 32'h11223344;
    @(posedge clk); #1;
    chk("rst_acc_mwe", {m_we, m_addr}, {1'b1, 32'h300});
    #2 reset = 1;
    #1;
    chk("rst_async_quiet", {m_we, m_size, m_addr, m_wdata, c_ack, l_ack, rdata}, 0);
    l_req = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_quiet", {m_we, c_ack, l_ack, rdata}, 0);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_no_ack", {c_ack, l_ack, m_we, m_addr}, 0);
    end
    chk("rst_no_write", mem[192], pat(192));
    $display("txn reset during loader write: access dropped");

    random_phase(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
